// File: rtl/hold_ctrl.sv
// Pipeline hold/jump controller: merges jump and per-requester hold levels,
// and adds a post-jump flush window, a debug-halt drain handshake and a hold watchdog.
module hold_ctrl #(
    parameter int                     ADDR_W       = 32,
    parameter int                     NUM_REQ      = 4,
    parameter logic [2*NUM_REQ-1:0]   REQ_LEVEL    = {2'd3, 2'd1, 2'd3, 2'd3},
    parameter int                     FLUSH_CYCLES = 1,
    parameter int                     DRAIN_CYCLES = 2,
    parameter int                     WDT_LIMIT    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_flag_i,
    input  logic [ADDR_W-1:0]   jump_addr_i,
    input  logic [NUM_REQ-1:0]  hold_req_i,
    input  logic                halt_req_i,
    output logic [2:0]          hold_flag_o,
    output logic                jump_flag_o,
    output logic [ADDR_W-1:0]   jump_addr_o,
    output logic [NUM_REQ-1:0]  hold_src_o,
    output logic                halt_ack_o,
    output logic                wdt_timeout_o
);

    localparam int FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int WW = $clog2(WDT_LIMIT + 1);

    localparam logic [FW-1:0] FLUSH_MAX  = FW'(FLUSH_CYCLES);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [WW-1:0] WDT_MAX    = WW'(WDT_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              r_state;
    logic [FW-1:0]       r_flush_cnt;
    logic [DW-1:0]       r_drain_cnt;
    logic [WW-1:0]       r_wdt_cnt;
    logic                r_halt_ack;
    logic                r_wdt_to;

    logic [1:0]          w_level;
    logic [NUM_REQ-1:0]  w_src;
    logic                w_quiet;
    logic [WW-1:0]       w_wdt_nxt;

    assign w_quiet = !jump_flag_i && (r_flush_cnt == '0);

    always_comb begin
        w_level = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hold_req_i[i] && (REQ_LEVEL[2*i +: 2] > w_level)) begin
                w_level = REQ_LEVEL[2*i +: 2];
            end
        end
        if (jump_flag_i || (r_flush_cnt != '0) || (r_state != ST_RUN)) begin
            w_level = 2'd3;
        end
    end

    always_comb begin
        w_src = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_src[i] = hold_req_i[i] && (REQ_LEVEL[2*i +: 2] == w_level) && (w_level != 2'd0);
        end
    end

    // Outputs are forced low while reset is held, even if inputs are active.
    assign hold_flag_o   = rst ? 3'b000 : {1'b0, w_level};
    assign hold_src_o    = rst ? '0 : w_src;
    assign jump_flag_o   = rst ? 1'b0 : jump_flag_i;
    assign jump_addr_o   = (rst || !jump_flag_i) ? '0 : jump_addr_i;
    assign halt_ack_o    = r_halt_ack;
    assign wdt_timeout_o = r_wdt_to;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
        end else if (jump_flag_i) begin
            r_flush_cnt <= FLUSH_MAX;
        end else if (r_flush_cnt != '0) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    // Drain only progresses on cycles with no jump in flight or flush pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_halt_ack  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_drain_cnt <= '0;
                    r_halt_ack  <= 1'b0;
                    if (halt_req_i) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!halt_req_i) begin
                        r_state     <= ST_RUN;
                        r_drain_cnt <= '0;
                    end else if (!w_quiet) begin
                        r_drain_cnt <= '0;
                    end else if (r_drain_cnt == DRAIN_LAST) begin
                        r_state     <= ST_HALTED;
                        r_halt_ack  <= 1'b1;
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!halt_req_i) begin
                        r_state     <= ST_RUN;
                        r_halt_ack  <= 1'b0;
                        r_drain_cnt <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_halt_ack  <= 1'b0;
                    r_drain_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_wdt_nxt = '0;
        if (|hold_req_i) begin
            w_wdt_nxt = (r_wdt_cnt == WDT_MAX) ? r_wdt_cnt : r_wdt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdt_cnt <= '0;
            r_wdt_to  <= 1'b0;
        end else begin
            r_wdt_cnt <= w_wdt_nxt;
            r_wdt_to  <= (w_wdt_nxt == WDT_MAX);
        end
    end

endmodule

// File: tb/tb_hold_ctrl.sv
// Directed bench for hold_ctrl: jump/flush, level merge, halt handshake,
// watchdog and asynchronous reset, with hand-computed expectations.
module tb_hold_ctrl;

    localparam int ADDR_W = 32;
    localparam int NREQ   = 4;

    logic              clk;
    logic              rst;
    logic              jump_flag_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic [NREQ-1:0]   hold_req_i;
    logic              halt_req_i;
    logic [2:0]        hold_flag_o;
    logic              jump_flag_o;
    logic [ADDR_W-1:0] jump_addr_o;
    logic [NREQ-1:0]   hold_src_o;
    logic              halt_ack_o;
    logic              wdt_timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    hold_ctrl #(
        .ADDR_W       (ADDR_W),
        .NUM_REQ      (NREQ),
        .REQ_LEVEL    (8'b11_01_11_11),
        .FLUSH_CYCLES (1),
        .DRAIN_CYCLES (2),
        .WDT_LIMIT    (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_req_i    (hold_req_i),
        .halt_req_i    (halt_req_i),
        .hold_flag_o   (hold_flag_o),
        .jump_flag_o   (jump_flag_o),
        .jump_addr_o   (jump_addr_o),
        .hold_src_o    (hold_src_o),
        .halt_ack_o    (halt_ack_o),
        .wdt_timeout_o (wdt_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each cycle: inputs change 1 unit after the rising edge, checks 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'hDEAD_BEEF;
        hold_req_i  = '0;
        halt_req_i  = 1'b0;
        #2;
        chk("rst_jump_flag", {31'd0, jump_flag_o}, 32'd0);
        chk("rst_jump_addr", jump_addr_o, 32'd0);
        chk("rst_hold_flag", {29'd0, hold_flag_o}, 32'd0);
        chk("rst_hold_src", {28'd0, hold_src_o}, 32'd0);
        chk("rst_halt_ack", {31'd0, halt_ack_o}, 32'd0);
        chk("rst_wdt", {31'd0, wdt_timeout_o}, 32'd0);
        jump_flag_i = 1'b0;
        jump_addr_i = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("idle_hold", {29'd0, hold_flag_o}, 32'd0);

        // Jump pulse then flush window
        tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0100;
        #1;
        chk("jmp_flag", {31'd0, jump_flag_o}, 32'd1);
        chk("jmp_addr", jump_addr_o, 32'h100);
        chk("jmp_hold0", {29'd0, hold_flag_o}, 32'd3);
        tick();
        jump_flag_i = 1'b0;
        #1;
        chk("jmp_addr_off", jump_addr_o, 32'd0);
        chk("jmp_hold1", {29'd0, hold_flag_o}, 32'd3);
        tick();
        #1;
        chk("jmp_hold2", {29'd0, hold_flag_o}, 32'd0);

        // Requester level merge
        tick();
        hold_req_i = 4'b0100;
        #1;
        chk("lvl_pc_flag", {29'd0, hold_flag_o}, 32'd1);
        chk("lvl_pc_src", {28'd0, hold_src_o}, 32'b0100);
        tick();
        hold_req_i = 4'b0101;
        #1;
        chk("lvl_id_flag", {29'd0, hold_flag_o}, 32'd3);
        chk("lvl_id_src", {28'd0, hold_src_o}, 32'b0001);
        tick();
        hold_req_i = 4'b0000;
        #1;
        chk("lvl_none", {29'd0, hold_flag_o}, 32'd0);

        // Halt with quiet pipeline: ack on the 3rd edge
        tick();
        halt_req_i = 1'b1;
        #1;
        chk("halt_t0_hold", {29'd0, hold_flag_o}, 32'd0);
        tick(); #1;
        chk("halt_t1_ack", {31'd0, halt_ack_o}, 32'd0);
        chk("halt_t1_hold", {29'd0, hold_flag_o}, 32'd3);
        tick(); #1;
        chk("halt_t2_ack", {31'd0, halt_ack_o}, 32'd0);
        chk("halt_t2_hold", {29'd0, hold_flag_o}, 32'd3);
        tick(); #1;
        chk("halt_t3_ack", {31'd0, halt_ack_o}, 32'd1);
        chk("halt_t3_hold", {29'd0, hold_flag_o}, 32'd3);
        tick();
        halt_req_i = 1'b0;
        #1;
        chk("unhalt_t0_ack", {31'd0, halt_ack_o}, 32'd1);
        tick(); #1;
        chk("unhalt_t1_ack", {31'd0, halt_ack_o}, 32'd0);
        chk("unhalt_t1_hold", {29'd0, hold_flag_o}, 32'd0);

        // Halt with a jump in the first DRAIN cycle: ack 2 cycles later
        tick();
        halt_req_i = 1'b1;
        tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0200;
        #1;
        chk("drjmp_pass", {31'd0, jump_flag_o}, 32'd1);
        chk("drjmp_addr", jump_addr_o, 32'h200);
        tick();
        jump_flag_i = 1'b0;
        #1;
        chk("drjmp_u2_ack", {31'd0, halt_ack_o}, 32'd0);
        tick(); #1;
        chk("drjmp_u3_ack", {31'd0, halt_ack_o}, 32'd0);
        tick(); #1;
        chk("drjmp_u4_ack", {31'd0, halt_ack_o}, 32'd0);
        chk("drjmp_u4_hold", {29'd0, hold_flag_o}, 32'd3);
        tick(); #1;
        chk("drjmp_u5_ack", {31'd0, halt_ack_o}, 32'd1);
        tick();
        halt_req_i = 1'b0;
        tick(); #1;
        chk("drjmp_rel_ack", {31'd0, halt_ack_o}, 32'd0);
        chk("drjmp_rel_hold", {29'd0, hold_flag_o}, 32'd0);

        // Halt dropped mid-DRAIN
        tick();
        halt_req_i = 1'b1;
        tick();
        halt_req_i = 1'b0;
        #1;
        chk("abort_drain_hold", {29'd0, hold_flag_o}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk("abort_ack", {31'd0, halt_ack_o}, 32'd0);
            chk("abort_hold", {29'd0, hold_flag_o}, 32'd0);
        end

        // Watchdog: 10-cycle hold with limit 8
        for (int i = 0; i < 10; i++) begin
            tick();
            hold_req_i = 4'b0010;
            #1;
            chk("wdt10", {31'd0, wdt_timeout_o}, (i >= 8) ? 32'd1 : 32'd0);
        end
        chk("wdt_src", {28'd0, hold_src_o}, 32'b0010);
        tick();
        hold_req_i = '0;
        #1;
        chk("wdt_rel0", {31'd0, wdt_timeout_o}, 32'd1);
        tick(); #1;
        chk("wdt_rel1", {31'd0, wdt_timeout_o}, 32'd0);

        // 7-cycle hold never times out
        for (int i = 0; i < 7; i++) begin
            tick();
            hold_req_i = 4'b0010;
            #1;
            chk("wdt7", {31'd0, wdt_timeout_o}, 32'd0);
        end
        tick();
        hold_req_i = '0;
        #1;
        chk("wdt7_rel", {31'd0, wdt_timeout_o}, 32'd0);
        tick(); #1;
        chk("wdt7_after", {31'd0, wdt_timeout_o}, 32'd0);

        // Reset while HALTED
        tick();
        halt_req_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("pre_rst_ack", {31'd0, halt_ack_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_halt_ack", {31'd0, halt_ack_o}, 32'd0);
        chk("rst_halt_hold", {29'd0, hold_flag_o}, 32'd0);
        tick();
        halt_req_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_hold", {29'd0, hold_flag_o}, 32'd0);
        chk("post_rst_ack", {31'd0, halt_ack_o}, 32'd0);

        // Reset mid-flush
        tick();
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h0000_0300;
        tick();
        jump_flag_i = 1'b0;
        #1;
        chk("flush_hold", {29'd0, hold_flag_o}, 32'd3);
        rst = 1'b1;
        jump_flag_i = 1'b1;
        #1;
        chk("rst_flush_hold", {29'd0, hold_flag_o}, 32'd0);
        chk("rst_flush_jump", {31'd0, jump_flag_o}, 32'd0);
        chk("rst_flush_addr", jump_addr_o, 32'd0);
        tick();
        jump_flag_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_flush_rst_hold", {29'd0, hold_flag_o}, 32'd0);
        tick(); #1;
        chk("post_flush_rst_hold2", {29'd0, hold_flag_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
